// File: rtl/toycpu_dmem_io_pkg.sv
// ============================================================================
//  Module   : toycpu_dmem_io_pkg
//  Desc     : Shared I/O offsets, STAT bit positions and serial TX states
//             for the toycpu data-side memory.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package toycpu_dmem_io_pkg;

    // I/O register offsets relative to IO_BASE
    localparam logic [15:0] IO_LED   = 16'd0;
    localparam logic [15:0] IO_TXD   = 16'd1;
    localparam logic [15:0] IO_STAT  = 16'd2;
    localparam logic [15:0] IO_TIMER = 16'd3;

    // STAT register bit positions
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/toycpu_dmem_io_if.sv
// ============================================================================
//  Module   : toycpu_dmem_io_if
//  Desc     : CPU data bus: word address, write strobe, write and read data.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface toycpu_dmem_io_if;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/toycpu_uart_tx.sv
// ============================================================================
//  Module   : toycpu_uart_tx
//  Desc     : 8N1 serial transmitter, byte-in with valid/ready, registered tx.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module toycpu_uart_tx
    import toycpu_dmem_io_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       in_valid,
    input  wire logic [7:0] in_data,
    output logic            in_ready,
    output logic            tx,
    output logic            busy
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            last_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign last_cycle = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        in_ready = 1'b0;
        case (state_q)
            TX_IDLE: begin
                cnt_d    = '0;
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = TX_START;
                    shift_d = in_data;
                end
            end
            TX_START: begin
                if (last_cycle) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (last_cycle) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (last_cycle) begin
                    // Accept the next byte here so consecutive frames abut.
                    cnt_d    = '0;
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_d = TX_START;
                        shift_d = in_data;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != TX_IDLE);

endmodule

`default_nettype wire

// File: rtl/toycpu_dmem_io.sv
// ============================================================================
//  Module   : toycpu_dmem_io
//  Desc     : Data RAM plus memory-mapped LED, serial TX FIFO, status and
//             optional cycle timer (enabled by TOYCPU_DMEM_TIMER_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module toycpu_dmem_io
    import toycpu_dmem_io_pkg::*;
#(
    parameter int          DMEM_AW    = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          BAUD_DIV   = 16,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  wire logic            clk,
    input  wire logic            rst,
    toycpu_dmem_io_if.slave      bus,
    output logic [7:0]           led,
    output logic                 tx
);

    localparam int RAM_WORDS = 1 << DMEM_AW;
    localparam int PW        = $clog2(FIFO_DEPTH);

    // ---------------- address decode ----------------
    logic        is_io;
    logic [15:0] io_off;
    logic        wr_ram, wr_led, wr_txd, wr_stat;

    assign is_io   = (bus.mem_addr >= IO_BASE);
    assign io_off  = bus.mem_addr - IO_BASE;
    assign wr_ram  = bus.mem_we && !is_io;
    assign wr_led  = bus.mem_we && is_io && (io_off == IO_LED);
    assign wr_txd  = bus.mem_we && is_io && (io_off == IO_TXD);
    assign wr_stat = bus.mem_we && is_io && (io_off == IO_STAT);

    // ---------------- data RAM ----------------
    logic [15:0] ram_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[bus.mem_addr[DMEM_AW-1:0]] <= bus.mem_wdata;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop;
    logic        tx_ready, tx_busy;

    // Both flags reflect state before this cycle's pop, so a write to a full
    // FIFO is dropped even if the transmitter frees a slot on the same edge.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push       = wr_txd && !fifo_full;
    assign pop        = tx_ready && !fifo_empty;
    assign wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= bus.mem_wdata[7:0];
        end
    end

    // ---------------- control registers ----------------
    logic [7:0] led_q, led_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        led_d = led_q;
        ovf_d = ovf_q;
        if (wr_led) begin
            led_d = bus.mem_wdata[7:0];
        end
        if (wr_stat) begin
            ovf_d = 1'b0;
        end
        if (wr_txd && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            led_q    <= led_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ---------------- optional cycle timer ----------------
    logic [15:0] timer_rd;

`ifdef TOYCPU_DMEM_TIMER_EN
    logic [15:0] timer_q, timer_d;

    assign timer_d = timer_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = 16'h0000;
`endif

    // ---------------- serial transmitter ----------------
    toycpu_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk      (clk),
        .rst      (rst),
        .in_valid (!fifo_empty),
        .in_data  (fifo_q[rd_ptr_q[PW-1:0]]),
        .in_ready (tx_ready),
        .tx       (tx),
        .busy     (tx_busy)
    );

    // ---------------- read path ----------------
    logic [15:0] stat_word;

    always_comb begin
        stat_word            = '0;
        stat_word[STAT_FULL]  = fifo_full;
        stat_word[STAT_EMPTY] = fifo_empty;
        stat_word[STAT_BUSY]  = tx_busy;
        stat_word[STAT_OVF]   = ovf_q;
    end

    always_comb begin
        bus.mem_rdata = 16'h0000;
        if (!is_io) begin
            bus.mem_rdata = ram_q[bus.mem_addr[DMEM_AW-1:0]];
        end else begin
            case (io_off)
                IO_LED:   bus.mem_rdata = {8'h00, led_q};
                IO_STAT:  bus.mem_rdata = stat_word;
                IO_TIMER: bus.mem_rdata = timer_rd;
                default:  bus.mem_rdata = 16'h0000;
            endcase
        end
    end

    assign led = led_q;

endmodule

`default_nettype wire

// File: tb/tb_toycpu_dmem_io.sv
// ============================================================================
//  Module   : tb_toycpu_dmem_io
//  Desc     : Directed self-checking bench for toycpu_dmem_io.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_toycpu_dmem_io;

    localparam int          DMEM_AW    = 8;
    localparam int          FIFO_DEPTH = 4;
    localparam int          BAUD_DIV   = 16;
    localparam logic [15:0] IO_BASE    = 16'hFF00;

    localparam logic [15:0] A_LED   = 16'hFF00;
    localparam logic [15:0] A_TXD   = 16'hFF01;
    localparam logic [15:0] A_STAT  = 16'hFF02;
    localparam logic [15:0] A_TIMER = 16'hFF03;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led;
    logic       tx;

    int n_tests = 0;
    int n_fail  = 0;

    toycpu_dmem_io_if dbus();

    toycpu_dmem_io #(
        .DMEM_AW    (DMEM_AW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_DIV   (BAUD_DIV),
        .IO_BASE    (IO_BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dbus),
        .led (led),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        dbus.mem_addr  = a;
        dbus.mem_we    = 1'b1;
        dbus.mem_wdata = d;
        @(posedge clk);
        #1;
        dbus.mem_we    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        dbus.mem_addr = a;
        #1;
        d = dbus.mem_rdata;
    endtask

    logic [15:0] r, t0, t1;
    logic [9:0]  frame;
    logic [7:0]  bytes4 [5];
    int          lows;

    initial begin
        dbus.mem_addr  = 16'h0000;
        dbus.mem_we    = 1'b0;
        dbus.mem_wdata = 16'h0000;
        cyc(3);
        rst = 1'b0;

        // Reset state
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_tx", {31'h0, tx}, 32'h1);
        rd(A_STAT, r);
        check("rst_stat", {16'h0, r}, 32'h0002);

        // T1: RAM write/read, alias and boundary, unmapped I/O
        wr(16'h0010, 16'h1234);
        rd(16'h0010, r);
        check("ram_rd", {16'h0, r}, 32'h1234);
        rd(16'h0110, r);
        check("ram_alias", {16'h0, r}, 32'h1234);
        wr(16'hFEFF, 16'hBEEF);
        rd(16'h00FF, r);
        check("ram_top_alias", {16'h0, r}, 32'hBEEF);
        rd(16'hFF05, r);
        check("io_unmapped", {16'h0, r}, 32'h0);
        rd(A_TXD, r);
        check("txd_read", {16'h0, r}, 32'h0);

        // T2: LED register and asynchronous reset
        wr(A_LED, 16'h12A5);
        check("led_out", {24'h0, led}, 32'hA5);
        rd(A_LED, r);
        check("led_rd", {16'h0, r}, 32'h00A5);
        rst = 1'b1;
        #1;
        check("led_async_rst", {24'h0, led}, 32'h0);
        rst = 1'b0;
        cyc(2);

        // T3: single frame of 0x55
        wr(A_TXD, 16'h0155);
        check("t3_tx_hold", {31'h0, tx}, 32'h1);
        cyc(1);
        check("t3_tx_start_edge", {31'h0, tx}, 32'h0);
        cyc(7);
        frame = '0;
        for (int b = 0; b < 10; b++) begin
            if (b != 0) cyc(BAUD_DIV);
            frame[b] = tx;
            if (b == 4) begin
                rd(A_STAT, r);
                check("t3_busy", {31'h0, r[2]}, 32'h1);
            end
        end
        check("t3_frame", {22'h0, frame}, {22'h0, 10'b1_0101_0101_0});
        cyc(BAUD_DIV);
        check("t3_idle_tx", {31'h0, tx}, 32'h1);
        rd(A_STAT, r);
        check("t3_idle_stat", {16'h0, r}, 32'h0002);

        // T4: FIFO overflow and back-to-back frames. The first byte moves to
        // the transmitter on the edge after its write, so five writes fill
        // the FIFO and the sixth overflows.
        bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33;
        bytes4[3] = 8'h44; bytes4[4] = 8'h55;
        for (int i = 0; i < 5; i++) wr(A_TXD, {8'h00, bytes4[i]});
        rd(A_STAT, r);
        check("t4_stat_full", {16'h0, r}, 32'h0005);
        wr(A_TXD, 16'h0066);
        rd(A_STAT, r);
        check("t4_stat_ovf", {16'h0, r}, 32'h000D);
        wr(A_STAT, 16'hFFFF);
        rd(A_STAT, r);
        check("t4_ovf_clear", {16'h0, r}, 32'h0005);
        cyc(3);
        for (int k = 0; k < 5; k++) begin
            frame = '0;
            for (int b = 0; b < 10; b++) begin
                if (k != 0 || b != 0) cyc(BAUD_DIV);
                frame[b] = tx;
            end
            check($sformatf("t4_frame%0d", k), {22'h0, frame},
                  {22'h0, 1'b1, bytes4[k], 1'b0});
        end
        cyc(BAUD_DIV);
        rd(A_STAT, r);
        check("t4_idle_stat", {16'h0, r}, 32'h0002);

        // T5: reset mid-DATA with a second byte queued
        wr(A_TXD, 16'h00F0);
        wr(A_TXD, 16'h000F);
        cyc(40);
        check("t5_tx_pre_rst", {31'h0, tx}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_tx_rst", {31'h0, tx}, 32'h1);
        #1;
        rst = 1'b0;
        rd(A_STAT, r);
        check("t5_stat", {16'h0, r}, 32'h0002);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (tx !== 1'b1) lows++;
        end
        check("t5_no_frames", lows, 0);

        // T6: timer
        cyc(1);
        rd(A_TIMER, t0);
        cyc(10);
        rd(A_TIMER, t1);
`ifdef TOYCPU_DMEM_TIMER_EN
        check("t6_timer_delta", {16'h0, t1 - t0}, 32'd10);
`else
        check("t6_timer_t0", {16'h0, t0}, 32'h0);
        check("t6_timer_t1", {16'h0, t1}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
